// File: rtl/viterbi_traceback_ring.sv
// rtl/viterbi_traceback_ring.sv - block-traceback survivor ring for the Viterbi decoder
module viterbi_traceback_ring #(
    parameter int K       = 7,
    parameter int TB_LEN  = 32,
    parameter int DEC_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**(K-1)-1:0]   surv_in,
    input  logic [K-2:0]          best_state,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DEC_LEN-1:0]    dec_out,
    output logic                  dec_valid,
    input  logic                  dec_ready
);
    localparam int SW        = K - 1;
    localparam int NS        = 2 ** SW;
    localparam int MEM_DEPTH = TB_LEN + DEC_LEN;
    localparam int PW        = $clog2(MEM_DEPTH);
    localparam int CW        = $clog2(MEM_DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST  = PW'(MEM_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(MEM_DEPTH);
    localparam logic [CW-1:0] CNT_KEEP  = CW'(TB_LEN);
    localparam logic [CW-1:0] STEP_LAST = CW'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {FILL, TRACE, OUT} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      step_q, step_d;
    logic [SW-1:0]      st_q, st_d;
    logic [DEC_LEN-1:0] sr_q, sr_d;
    logic               dec_valid_q, dec_valid_d;

    logic [NS-1:0]      ring_q [MEM_DEPTH];
    logic               ring_we;
    logic [NS-1:0]      surv_rd;
    logic               dec_bit;

    assign surv_rd   = ring_q[rd_ptr_q];
    assign dec_bit   = st_q[SW-1];
    assign in_ready  = (state_q == FILL);
    assign dec_out   = sr_q;
    assign dec_valid = dec_valid_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        step_d      = step_q;
        st_d        = st_q;
        sr_d        = sr_q;
        dec_valid_d = dec_valid_q;
        ring_we     = 1'b0;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    ring_we  = 1'b1;
                    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
                    count_d  = count_q + CW'(1);
                    if (count_q + CW'(1) == CNT_FULL) begin
                        st_d     = best_state;
                        rd_ptr_d = wr_ptr_q;
                        step_d   = '0;
                        state_d  = TRACE;
                    end
                end
            end
            TRACE: begin
                // Walk backwards in time: newest entry first, predecessor from the decision bit.
                st_d     = {st_q[SW-2:0], surv_rd[st_q]};
                rd_ptr_d = (rd_ptr_q == '0) ? PTR_LAST : rd_ptr_q - PW'(1);
                step_d   = step_q + CW'(1);
                if (step_q >= CNT_KEEP) begin
                    sr_d = (sr_q << 1) | DEC_LEN'(dec_bit);
                end
                if (step_q == STEP_LAST) begin
                    state_d     = OUT;
                    dec_valid_d = 1'b1;
                end
            end
            OUT: begin
                if (dec_ready) begin
                    dec_valid_d = 1'b0;
                    count_d     = CNT_KEEP;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            step_q      <= '0;
            st_q        <= '0;
            sr_q        <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            step_q      <= step_d;
            st_q        <= st_d;
            sr_q        <= sr_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    // Survivor storage is never cleared; a full window is always written before it is read.
    always_ff @(posedge clk) begin
        if (ring_we) begin
            ring_q[wr_ptr_q] <= surv_in;
        end
    end
endmodule
